// File: rtl/instr_sequencer.sv
// instr_sequencer: fetches instruction words (and the LDI immediate) from
// instruction memory over a request/valid handshake, then steps the control
// unit through four execution cycles per instruction.
module instr_sequencer #(
  parameter int DATA_W = 9,
  parameter int PC_W   = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              run,
  output logic              mem_rd,
  output logic [PC_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_valid,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] imm,
  output logic [1:0]        count,
  output logic              exec,
  output logic              done,
  output logic              halted
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    FETCH_IMM,
    EXEC,
    HALTED
  } state_t;

  localparam logic [2:0] OP_LDI  = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b110;

  state_t            state;
  state_t            state_next;
  logic [PC_W-1:0]   pc;
  logic              fetch_accept;
  logic [2:0]        opcode;

  assign opcode   = mem_data[DATA_W-1 -: 3];
  assign mem_addr = pc;

  // State register; reset aborts any pending fetch immediately.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state selection and state-decoded outputs (no input feeds an output).
  always_comb begin
    state_next   = state;
    mem_rd       = 1'b0;
    exec         = 1'b0;
    done         = 1'b0;
    halted       = 1'b0;
    fetch_accept = 1'b0;
    case (state)
      IDLE: begin
        if (run) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        mem_rd = 1'b1;
        if (mem_valid) begin
          fetch_accept = 1'b1;
          case (opcode)
            OP_LDI:  state_next = FETCH_IMM;
            OP_HALT: state_next = HALTED;
            default: state_next = EXEC;
          endcase
        end
      end
      FETCH_IMM: begin
        mem_rd = 1'b1;
        if (mem_valid) begin
          fetch_accept = 1'b1;
          state_next   = EXEC;
        end
      end
      EXEC: begin
        exec = 1'b1;
        done = (count == 2'd3);
        if (count == 2'd3) begin
          state_next = run ? FETCH : IDLE;
        end
      end
      HALTED: begin
        halted = 1'b1;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: pc, instruction/immediate registers and the execution step counter.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      pc    <= '0;
      instr <= '0;
      imm   <= '0;
      count <= 2'd0;
    end else begin
      if (fetch_accept) begin
        pc <= pc + 1'b1;
      end
      if (fetch_accept && (state == FETCH)) begin
        instr <= mem_data;
      end
      if (fetch_accept && (state == FETCH_IMM)) begin
        imm <= mem_data;
      end
      count <= (state == EXEC) ? count + 2'd1 : 2'd0;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: table-driven check of a short program on an 8-bit-pc
// sequencer, plus hand-written latency, halt/reset and pc-wrap sequences.
module tb_instr_sequencer;

  logic       clk;
  logic       resetn;
  logic       run;
  logic       mem_rd;
  logic [7:0] mem_addr;
  logic [8:0] mem_data;
  logic       mem_valid;
  logic [8:0] instr;
  logic [8:0] imm;
  logic [1:0] count;
  logic       exec;
  logic       done;
  logic       halted;

  logic       resetn_s;
  logic       run_s;
  logic       mem_rd_s;
  logic [1:0] mem_addr_s;
  logic [8:0] mem_data_s;
  logic       mem_valid_s;
  logic [8:0] instr_s;
  logic [8:0] imm_s;
  logic [1:0] count_s;
  logic       exec_s;
  logic       done_s;
  logic       halted_s;

  logic [8:0] mem   [0:255];
  logic [8:0] mem_s [0:3];
  int         lat_extra;
  int         rd_cycles;
  logic       stray_valid;
  logic [8:0] stray_data;

  int num_checks;
  int num_errors;

  typedef struct {
    logic       run;
    logic       exp_rd;
    logic [7:0] exp_addr;
    logic [8:0] exp_instr;
    logic [8:0] exp_imm;
    logic [1:0] exp_count;
    logic       exp_exec;
    logic       exp_done;
    logic       exp_halted;
  } vec_t;

  vec_t vq[$];

  instr_sequencer #(.DATA_W(9), .PC_W(8)) dut (
    .clk(clk), .resetn(resetn), .run(run),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data), .mem_valid(mem_valid),
    .instr(instr), .imm(imm), .count(count), .exec(exec), .done(done), .halted(halted)
  );

  instr_sequencer #(.DATA_W(9), .PC_W(2)) dut_wrap (
    .clk(clk), .resetn(resetn_s), .run(run_s),
    .mem_rd(mem_rd_s), .mem_addr(mem_addr_s), .mem_data(mem_data_s), .mem_valid(mem_valid_s),
    .instr(instr_s), .imm(imm_s), .count(count_s), .exec(exec_s), .done(done_s), .halted(halted_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: answers after lat_extra wait cycles, plus injectable stray strobes.
  assign mem_valid   = (mem_rd && (rd_cycles == lat_extra)) || stray_valid;
  assign mem_data    = stray_valid ? stray_data : mem[mem_addr];
  assign mem_valid_s = mem_rd_s;
  assign mem_data_s  = mem_s[mem_addr_s];

  // Counts wait cycles of the current outstanding request.
  always @(posedge clk or posedge resetn) begin
    if (resetn) begin
      rd_cycles <= 0;
    end else if (mem_rd && !mem_valid) begin
      rd_cycles <= rd_cycles + 1;
    end else begin
      rd_cycles <= 0;
    end
  end

  // Watchdog so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkField(input string name, input logic [15:0] act, input logic [15:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic addVec(input logic r, input logic rd, input logic [7:0] a,
                        input logic [8:0] in, input logic [8:0] im, input logic [1:0] c,
                        input logic ex, input logic dn, input logic hl);
    vec_t v;
    v.run = r; v.exp_rd = rd; v.exp_addr = a; v.exp_instr = in; v.exp_imm = im;
    v.exp_count = c; v.exp_exec = ex; v.exp_done = dn; v.exp_halted = hl;
    vq.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    run = v.run;
  endtask

  task automatic checkOutput(input vec_t v, input int row);
    checkField($sformatf("r%0d.mem_rd", row),   16'(mem_rd),   16'(v.exp_rd));
    checkField($sformatf("r%0d.mem_addr", row), 16'(mem_addr), 16'(v.exp_addr));
    checkField($sformatf("r%0d.instr", row),    16'(instr),    16'(v.exp_instr));
    checkField($sformatf("r%0d.imm", row),      16'(imm),      16'(v.exp_imm));
    checkField($sformatf("r%0d.count", row),    16'(count),    16'(v.exp_count));
    checkField($sformatf("r%0d.exec", row),     16'(exec),     16'(v.exp_exec));
    checkField($sformatf("r%0d.done", row),     16'(done),     16'(v.exp_done));
    checkField($sformatf("r%0d.halted", row),   16'(halted),   16'(v.exp_halted));
  endtask

  int   rd_seen;
  logic got;
  int   nf;

  initial begin
    num_checks  = 0;
    num_errors  = 0;
    resetn      = 1'b1;
    resetn_s    = 1'b1;
    run         = 1'b0;
    run_s       = 1'b0;
    lat_extra   = 0;
    stray_valid = 1'b0;
    stray_data  = 9'h000;

    for (int i = 0; i < 256; i++) mem[i] = 9'h0C0;
    mem[0] = 9'h00A;
    mem[1] = 9'h158;
    mem[2] = 9'h05A;
    mem[3] = 9'h049;
    mem[4] = 9'h180;
    mem_s[0] = 9'h00A;
    mem_s[1] = 9'h00B;
    mem_s[2] = 9'h00C;
    mem_s[3] = 9'h00D;

    //      run   rd    addr   instr    imm      cnt   exec  done  halt
    addVec(1'b1, 1'b0, 8'd0, 9'h000, 9'h000, 2'd0, 1'b0, 1'b0, 1'b0);
    addVec(1'b1, 1'b1, 8'd0, 9'h000, 9'h000, 2'd0, 1'b0, 1'b0, 1'b0);
    addVec(1'b1, 1'b0, 8'd1, 9'h00A, 9'h000, 2'd0, 1'b1, 1'b0, 1'b0);
    addVec(1'b1, 1'b0, 8'd1, 9'h00A, 9'h000, 2'd1, 1'b1, 1'b0, 1'b0);
    addVec(1'b1, 1'b0, 8'd1, 9'h00A, 9'h000, 2'd2, 1'b1, 1'b0, 1'b0);
    addVec(1'b1, 1'b0, 8'd1, 9'h00A, 9'h000, 2'd3, 1'b1, 1'b1, 1'b0);
    addVec(1'b1, 1'b1, 8'd1, 9'h00A, 9'h000, 2'd0, 1'b0, 1'b0, 1'b0);
    addVec(1'b1, 1'b1, 8'd2, 9'h158, 9'h000, 2'd0, 1'b0, 1'b0, 1'b0);
    addVec(1'b1, 1'b0, 8'd3, 9'h158, 9'h05A, 2'd0, 1'b1, 1'b0, 1'b0);
    addVec(1'b1, 1'b0, 8'd3, 9'h158, 9'h05A, 2'd1, 1'b1, 1'b0, 1'b0);
    addVec(1'b1, 1'b0, 8'd3, 9'h158, 9'h05A, 2'd2, 1'b1, 1'b0, 1'b0);
    addVec(1'b1, 1'b0, 8'd3, 9'h158, 9'h05A, 2'd3, 1'b1, 1'b1, 1'b0);
    addVec(1'b1, 1'b1, 8'd3, 9'h158, 9'h05A, 2'd0, 1'b0, 1'b0, 1'b0);
    addVec(1'b1, 1'b0, 8'd4, 9'h049, 9'h05A, 2'd0, 1'b1, 1'b0, 1'b0);
    addVec(1'b0, 1'b0, 8'd4, 9'h049, 9'h05A, 2'd1, 1'b1, 1'b0, 1'b0);
    addVec(1'b0, 1'b0, 8'd4, 9'h049, 9'h05A, 2'd2, 1'b1, 1'b0, 1'b0);
    addVec(1'b0, 1'b0, 8'd4, 9'h049, 9'h05A, 2'd3, 1'b1, 1'b1, 1'b0);
    addVec(1'b0, 1'b0, 8'd4, 9'h049, 9'h05A, 2'd0, 1'b0, 1'b0, 1'b0);
    addVec(1'b1, 1'b0, 8'd4, 9'h049, 9'h05A, 2'd0, 1'b0, 1'b0, 1'b0);
    addVec(1'b1, 1'b1, 8'd4, 9'h049, 9'h05A, 2'd0, 1'b0, 1'b0, 1'b0);
    addVec(1'b1, 1'b0, 8'd5, 9'h180, 9'h05A, 2'd0, 1'b0, 1'b0, 1'b1);
    addVec(1'b1, 1'b0, 8'd5, 9'h180, 9'h05A, 2'd0, 1'b0, 1'b0, 1'b1);
    addVec(1'b1, 1'b0, 8'd5, 9'h180, 9'h05A, 2'd0, 1'b0, 1'b0, 1'b1);

    repeat (2) @(negedge clk);
    resetn = 1'b0;

    // Program run: ADD, LDI + immediate, SUB with run dropped in step 1, HALT.
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      applyStimulus(vq[i]);
      checkOutput(vq[i], i);
    end

    // Asynchronous reset out of HALTED.
    #2 resetn = 1'b1;
    #1;
    checkField("halt_reset.halted", 16'(halted),   16'(1'b0));
    checkField("halt_reset.pc",     16'(mem_addr), 16'(8'd0));
    checkField("halt_reset.instr",  16'(instr),    16'(9'h000));
    checkField("halt_reset.imm",    16'(imm),      16'(9'h000));
    @(negedge clk);
    resetn = 1'b0;
    run    = 1'b0;

    // Slow memory: 3-cycle latency, stray strobes while not requesting.
    lat_extra = 2;
    @(negedge clk);
    stray_data  = 9'h1FF;
    stray_valid = 1'b1;
    @(negedge clk);
    stray_valid = 1'b0;
    checkField("stray_idle.instr",  16'(instr),  16'(9'h000));
    checkField("stray_idle.mem_rd", 16'(mem_rd), 16'(1'b0));
    run     = 1'b1;
    rd_seen = 0;
    got     = 1'b0;
    for (int k = 0; k < 12 && !got; k++) begin
      @(negedge clk);
      if (exec) begin
        got = 1'b1;
      end else if (mem_rd) begin
        rd_seen++;
        checkField("lat.instr_hold", 16'(instr), 16'(9'h000));
        checkField("lat.count_hold", 16'(count), 16'(2'd0));
      end
    end
    checkField("lat.exec_reached", 16'(got),     16'(1'b1));
    checkField("lat.rd_cycles",    16'(rd_seen), 16'(3));
    checkField("lat.instr",        16'(instr),   16'(9'h00A));
    checkField("lat.count0",       16'(count),   16'(2'd0));
    run         = 1'b0;
    stray_valid = 1'b1;
    @(negedge clk);
    stray_valid = 1'b0;
    checkField("stray_exec.instr", 16'(instr), 16'(9'h00A));
    checkField("stray_exec.count", 16'(count), 16'(2'd1));
    repeat (3) @(negedge clk);
    checkField("lat_idle.mem_rd", 16'(mem_rd),   16'(1'b0));
    checkField("lat_idle.exec",   16'(exec),     16'(1'b0));
    checkField("lat_idle.pc",     16'(mem_addr), 16'(8'd1));
    lat_extra = 0;

    // Two-bit pc: fetch addresses wrap 0,1,2,3,0; reset mid-FETCH clears everything.
    @(negedge clk);
    resetn_s = 1'b0;
    run_s    = 1'b1;
    nf       = 0;
    for (int k = 0; k < 60 && nf < 6; k++) begin
      @(negedge clk);
      if (mem_rd_s) begin
        checkField($sformatf("wrap.addr%0d", nf), 16'(mem_addr_s), 16'(nf % 4));
        nf++;
        if (nf == 6) begin
          checkField("wrap.instr_after_wrap", 16'(instr_s), 16'(9'h00A));
          #2 resetn_s = 1'b1;
          #1;
          checkField("rst_fetch.mem_rd", 16'(mem_rd_s),   16'(1'b0));
          checkField("rst_fetch.pc",     16'(mem_addr_s), 16'(2'd0));
          checkField("rst_fetch.instr",  16'(instr_s),    16'(9'h000));
          checkField("rst_fetch.imm",    16'(imm_s),      16'(9'h000));
          checkField("rst_fetch.count",  16'(count_s),    16'(2'd0));
          checkField("rst_fetch.exec",   16'(exec_s),     16'(1'b0));
          checkField("rst_fetch.done",   16'(done_s),     16'(1'b0));
          checkField("rst_fetch.halted", 16'(halted_s),   16'(1'b0));
        end
      end
    end
    checkField("wrap.fetch_count", 16'(nf), 16'(6));

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Fetch-and-step sequencer that sits directly upstream of the control unit. It reads 9-bit instruction words from instruction memory through a request/valid handshake and holds each in an instruction register. For `LDI` it also fetches the following word as the immediate. It then drives the 2-bit step counter through the four execution steps consumed by the control unit.

## Interface
- `DATA_W`, 9: instruction/immediate word width; opcode is bits [8:6].
- `PC_W`, 8: program counter width; instruction memory depth is 2^PC_W words.

- `clk`  in  1  system clock, rising edge.
- `resetn`  in  1  reset, asynchronous, active-high.
- `run`  in  1  level; permits fetching of new instructions.
- `mem_rd`  out  1  fetch request, held high until `mem_valid`.
- `mem_addr`  out  PC_W  fetch address (= `pc`).
- `mem_data`  in  DATA_W  fetched word, sampled when `mem_valid` = 1.
- `mem_valid`  in  1  one-cycle response strobe; ignored while `mem_rd` = 0.
- `instr`  out  DATA_W  instruction register; drives the control unit `in`.
- `imm`  out  DATA_W  immediate register for `LDI`.
- `count`  out  2  execution step 0..3; drives the control unit `count`.
- `exec`  out  1  high while `count` is a valid execution step.
- `done`  out  1  one-cycle pulse in step 3 of every executed instruction.
- `halted`  out  1  high in HALTED.

## Operation
- States: IDLE, FETCH, FETCH_IMM, EXEC, HALTED.
- IDLE:
  - `run` = 1 -> FETCH.
  - Otherwise remain in IDLE; `instr` and `imm` hold their last values.
- FETCH: `mem_rd` = 1, `mem_addr` = `pc`. On `mem_valid`:
  - `instr` <= `mem_data`; `pc` <= `pc`+1 (mod 2^PC_W).
  - Next state is chosen by the opcode `mem_data[8:6]`:
    - 101 (LDI) -> FETCH_IMM.
    - 110 (HALT) -> HALTED.
    - any other opcode (000 ADD, 001 SUB, 010 NAND, 011 NOP, 100 OUT, 111 REP) -> EXEC with `count` = 0.
- FETCH_IMM: `mem_rd` = 1, `mem_addr` = `pc`. On `mem_valid`:
  - `imm` <= `mem_data`; `pc` <= `pc`+1.
  - -> EXEC with `count` = 0.
- EXEC:
  - `exec` = 1; `count` advances 0,1,2,3, one step per cycle.
  - `done` = 1 during `count` = 3.
  - After step 3: `run` = 1 -> FETCH; `run` = 0 -> IDLE.
- HALTED:
  - `halted` = 1, no fetches. The only exit is `resetn`.
  - The HALT word is written to `instr` but is never executed (`exec` stays 0).
- `run` deassertion mid-FETCH, mid-FETCH_IMM or mid-EXEC does not abort the instruction. The instruction completes and the sequencer then enters IDLE.
- Outside EXEC: `count` = 0, `exec` = 0.
- `instr` and `imm` change only on an accepted `mem_valid`, so they are stable through all four EXEC cycles.
- `imm` is not cleared by non-LDI instructions.

## Timing
- Reset values (asynchronous, immediate on `resetn` = 1):
  - state = IDLE.
  - `pc` = 0, `instr` = 0, `imm` = 0, `count` = 0.
  - `mem_rd` = 0, `exec` = 0, `done` = 0, `halted` = 0.
- Reset asserted mid-operation aborts any pending fetch; `mem_rd` drops at once.
- All state, `pc` and register updates occur on the rising `clk` edge; outputs are registered or decoded from state only.
- Memory latency is arbitrary, ≥1 cycle.
  - `mem_valid` in the same cycle `mem_rd` first rises is accepted: zero-wait memory.
  - With zero-wait memory:
    - Non-LDI instruction: 1 FETCH + 4 EXEC = 5 cycles per instruction.
    - LDI: 6 cycles.
- IDLE -> FETCH costs one cycle. `run` held high through EXEC step 3 chains straight into FETCH with no IDLE cycle.
- `pc` wrap: at 2^PC_W−1, increment yields 0 with no other side effect.
- If `mem_valid` and `resetn` occur together, reset wins.

## Test plan
- Reset then `run` = 1, memory word 0 = 9'b000_001_010 (ADD), zero-wait:
  - `mem_rd` with `mem_addr` = 0 for 1 cycle.
  - `instr` = 0x00A.
  - `count` 0,1,2,3 with `exec` = 1.
  - `done` pulses in step 3.
  - `pc` = 1.
- LDI at addr 0 (9'b101_011_000), word 1 = 9'h05A, word 2 = ADD:
  - `imm` = 0x05A before `count` = 0.
  - LDI execution occupies cycles 3–6.
  - Next fetch is at `mem_addr` = 2.
- Memory with 3-cycle latency:
  - `mem_rd` held high 3 cycles.
  - `instr` and `count` unchanged until `mem_valid`.
  - `mem_valid` pulses while `mem_rd` = 0 are ignored.
- `run` dropped during EXEC step 1:
  - Steps 2 and 3 still occur and `done` pulses.
  - Sequencer then in IDLE with `mem_rd` = 0.
  - Raising `run` restarts fetching at the next `pc`.
- HALT (9'b110_000_000) at addr 3:
  - `halted` = 1 after acceptance, `exec` never set, no further `mem_rd`.
  - `resetn` pulse returns to IDLE with `pc` = 0.
- `pc` wrap with PC_W = 2, 4 consecutive ADDs:
  - Addresses 0,1,2,3,0.
  - `resetn` asserted mid-FETCH clears all outputs in the same cycle.
